queue_flow_ctrl: RTL
====================

// Module: queue_flow_ctrl
// PURPOSE
//  Scheduler between the deserializer and the 8-entry byte queue, in the 1 MHz domain.
//  Generates one-cycle tick enables replacing the divided 100 KHz / 10 KHz clocks.
//  Arbitrates deserializer enqueue requests and consumer dequeue requests onto the queue's
//  command inputs, one command per slow slot.
//  Confirms each command via the queue length, then acks the requester.
// PARAMETERS
//  DIV_FAST  10   clock_1MHz cycles per tick_fast_out (100 KHz)
//  DIV_SLOW  100  clock_1MHz cycles per tick_slow_out (10 KHz); one command slot
//  DEPTH     8    queue capacity in bytes; LW = $clog2(DEPTH+1) = 4
//  TIMEOUT   4    slow slots allowed for the length change before error
// PORTS
//  clock_1MHz    in   1   single clock, all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  des_ready_in  in   1   deserializer byte valid; level, held until des_ack_out
//  des_data_in   in   8   deserializer byte, stable while des_ready_in=1
//  des_ack_out   out  1   1-cycle pulse: byte confirmed in queue
//  deq_req_in    in   1   consumer dequeue request; 1-cycle pulse, latched
//  deq_done_out  out  1   1-cycle pulse: dequeue confirmed
//  q_enqueue_out out  1   queue enqueue command, held one full slot
//  q_dequeue_out out  1   queue dequeue command, held one full slot
//  q_data_out    out  8   byte presented to queue, valid with q_enqueue_out
//  q_len_in      in   LW  queue occupancy, 0..DEPTH
//  tick_fast_out out  1   1-cycle enable every DIV_FAST cycles
//  tick_slow_out out  1   1-cycle enable every DIV_SLOW cycles
//  full_out      out  1   comb: q_len_in == DEPTH
//  empty_out     out  1   comb: q_len_in == 0
//  err_out       out  1   sticky: command not confirmed within TIMEOUT slots
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - All registered outputs go to 0; tick counters go to 0.
//   - deq_pending=0, err_out=0, last_grant=DEQ (so ENQ wins the first tie); state=IDLE.
//   - Reset mid-command aborts it, with no ack.
//  Ticks:
//   - Free-running counters; tick_x_out=1 in the cycle the counter equals DIV_x-1, then the counter wraps to 0.
//   - First tick_slow_out occurs DIV_SLOW cycles after rst is released.
//  deq_pending:
//   - Set by deq_req_in; cleared only on the deq_done_out cycle.
//   - A request in the same cycle as deq_done_out leaves it set.
//   - A request while already pending is absorbed; at most 1 is outstanding.
//  Eligibility:
//   - enq_ok = des_ready_in && q_len_in < DEPTH
//   - deq_ok = deq_pending && q_len_in > 0
//   - Full blocks ENQ and empty blocks DEQ; there is no overflow or underflow path.
//  FSM:
//   IDLE: on tick_slow_out, if enq_ok or deq_ok, grant.
//    - One eligible request: grant it.
//    - Both eligible: grant the opposite of last_grant (round-robin).
//    - On grant: snapshot len_snap <= q_len_in, q_data_out <= des_data_in (ENQ only),
//      assert the command, set last_grant, go to ISSUE.
//   ISSUE:
//    - Hold the command until the next tick_slow_out (exactly DIV_SLOW cycles).
//    - In that cycle deassert it, load slot_cnt=0, go to CHECK.
//   CHECK: each cycle, compare q_len_in with len_snap+1 (ENQ) or len_snap-1 (DEQ).
//    - Match: pulse des_ack_out (ENQ) or deq_done_out (DEQ) for 1 cycle; go to IDLE.
//    - On each tick_slow_out without a match, slot_cnt++.
//    - When slot_cnt reaches TIMEOUT: set err_out, go to IDLE with no ack.
//      The request stays pending and is retried.
//  Latency:
//   - Grant is at the first slow tick with a request eligible.
//   - The ack comes at least DIV_SLOW+1 cycles after the grant.
//   - Throughput is at most 1 command per 2 slots.
//  Arithmetic:
//   - len_snap +/- 1 is computed in LW bits.
//   - Guards keep it within 0..DEPTH, so it never wraps.
//  Stability:
//   - q_data_out is stable for the whole command.
//   - des_ready_in dropping during ISSUE/CHECK does not cancel the command.
// TESTING
//  1 Reset: hold rst 3 cycles mid-ISSUE -> all outputs 0, FSM in IDLE, command dropped, no ack.
//  2 Ticks: 1000 cycles after reset -> 100 tick_fast_out and 10 tick_slow_out pulses,
//    each 1 cycle, spaced 10 and 100 cycles.
//  3 Enqueue: des_ready_in=1, des_data_in=8'hA5, len 0 -> q_enqueue_out high 100 cycles
//    with q_data_out=A5; model len=1; then des_ack_out pulses once.
//  4 Tie: len=3, deq_pending=1 and des_ready_in=1 -> ENQ granted first, then DEQ in the
//    next eligible slot; deq_done_out pulses and len returns to 3.
//  5 Bounds: len=8 with des_ready_in=1 -> no q_enqueue_out, full_out=1;
//    len=0 with deq_req_in -> no q_dequeue_out, and deq_pending is still held.
//  6 Timeout: model never changes len -> err_out=1 after 4 slots in CHECK,
//    no des_ack_out, and the command is reissued.

Source files
------------

// File: rtl/queue_flow_ctrl.sv
// queue_flow_ctrl: slot scheduler between the deserializer and the 8-entry byte queue.
// Derives 100 KHz / 10 KHz tick enables from clock_1MHz and issues at most one
// enqueue or dequeue command per slow slot. Each command is confirmed by watching
// the queue length move, and only then is the requester acknowledged.
module queue_flow_ctrl #(
  parameter int DIV_FAST = 10,
  parameter int DIV_SLOW = 100,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 4,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic          clock_1MHz,
  input  logic          rst,
  input  logic          des_ready_in,
  input  logic [7:0]    des_data_in,
  output logic          des_ack_out,
  input  logic          deq_req_in,
  output logic          deq_done_out,
  output logic          q_enqueue_out,
  output logic          q_dequeue_out,
  output logic [7:0]    q_data_out,
  input  logic [LW-1:0] q_len_in,
  output logic          tick_fast_out,
  output logic          tick_slow_out,
  output logic          full_out,
  output logic          empty_out,
  output logic          err_out
);

  localparam int FW = $clog2(DIV_FAST);
  localparam int SW = $clog2(DIV_SLOW);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FAST_LAST  = FW'(DIV_FAST - 1);
  localparam logic [SW-1:0] SLOW_LAST  = SW'(DIV_SLOW - 1);
  localparam logic [LW-1:0] LEN_FULL   = LW'(DEPTH);
  localparam logic [CW-1:0] SLOT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
  typedef enum logic {GRANT_ENQ, GRANT_DEQ} grant_t;

  logic [FW-1:0] fast_cnt;
  logic [SW-1:0] slow_cnt;
  logic          deq_pending;
  logic          enq_ok;
  logic          deq_ok;
  logic          pick_enq;
  logic [LW-1:0] exp_len;

  state_t        state, state_n;
  grant_t        last_grant, last_grant_n;
  logic [LW-1:0] len_snap, len_snap_n;
  logic [CW-1:0] slot_cnt, slot_cnt_n;
  logic [7:0]    data_n;
  logic          enq_cmd_n, deq_cmd_n, ack_n, done_n, err_n;

  assign tick_fast_out = (fast_cnt == FAST_LAST);
  assign tick_slow_out = (slow_cnt == SLOW_LAST);
  assign full_out      = (q_len_in == LEN_FULL);
  assign empty_out     = (q_len_in == '0);
  assign enq_ok        = des_ready_in && (q_len_in < LEN_FULL);
  assign deq_ok        = deq_pending && (q_len_in != '0);

  // Free-running tick dividers; each wraps to 0 on its own tick cycle
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      fast_cnt <= '0;
      slow_cnt <= '0;
    end else begin
      fast_cnt <= tick_fast_out ? '0 : fast_cnt + FW'(1);
      slow_cnt <= tick_slow_out ? '0 : slow_cnt + SW'(1);
    end
  end

  // Single outstanding dequeue request; a new request on the done cycle re-arms it
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      deq_pending <= 1'b0;
    end else if (deq_req_in) begin
      deq_pending <= 1'b1;
    end else if (deq_done_out) begin
      deq_pending <= 1'b0;
    end
  end

  // FSM state and registered command/ack outputs
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= GRANT_DEQ;
      len_snap      <= '0;
      slot_cnt      <= '0;
      q_data_out    <= '0;
      q_enqueue_out <= 1'b0;
      q_dequeue_out <= 1'b0;
      des_ack_out   <= 1'b0;
      deq_done_out  <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      state         <= state_n;
      last_grant    <= last_grant_n;
      len_snap      <= len_snap_n;
      slot_cnt      <= slot_cnt_n;
      q_data_out    <= data_n;
      q_enqueue_out <= enq_cmd_n;
      q_dequeue_out <= deq_cmd_n;
      des_ack_out   <= ack_n;
      deq_done_out  <= done_n;
      err_out       <= err_n;
    end
  end

  // Grant / hold / confirm sequencing; last_grant doubles as the op in flight
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    len_snap_n   = len_snap;
    slot_cnt_n   = slot_cnt;
    data_n       = q_data_out;
    enq_cmd_n    = q_enqueue_out;
    deq_cmd_n    = q_dequeue_out;
    ack_n        = 1'b0;
    done_n       = 1'b0;
    err_n        = err_out;
    pick_enq     = 1'b0;
    exp_len      = (last_grant == GRANT_ENQ) ? (len_snap + LW'(1)) : (len_snap - LW'(1));
    case (state)
      IDLE: begin
        if (tick_slow_out && (enq_ok || deq_ok)) begin
          if (enq_ok && deq_ok) begin
            pick_enq = (last_grant == GRANT_DEQ);
          end else begin
            pick_enq = enq_ok;
          end
          len_snap_n = q_len_in;
          state_n    = ISSUE;
          if (pick_enq) begin
            data_n       = des_data_in;
            enq_cmd_n    = 1'b1;
            last_grant_n = GRANT_ENQ;
          end else begin
            deq_cmd_n    = 1'b1;
            last_grant_n = GRANT_DEQ;
          end
        end
      end
      ISSUE: begin
        if (tick_slow_out) begin
          enq_cmd_n  = 1'b0;
          deq_cmd_n  = 1'b0;
          slot_cnt_n = '0;
          state_n    = CHECK;
        end
      end
      CHECK: begin
        if (q_len_in == exp_len) begin
          ack_n   = (last_grant == GRANT_ENQ);
          done_n  = (last_grant == GRANT_DEQ);
          state_n = IDLE;
        end else if (tick_slow_out) begin
          slot_cnt_n = slot_cnt + CW'(1);
          if (slot_cnt + CW'(1) == SLOT_LIMIT) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
